mult_div_unit: RTL

- Iterative multiply/divide unit in the EX stage, directly downstream of the register file.
- Consumes the two register read operands (rs/rt data) and executes MULT, MULTU, DIV and DIVU.
- Holds the results in architectural HI/LO registers.
- Multi-cycle, with a start/busy/done handshake the hazard logic uses to stall the pipeline.

---
 rtl/mult_div_unit.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One operand bit is processed per clock: shift-add for MULT/MULTU and
// restoring shift-subtract for DIV/DIVU, on operand magnitudes, followed by
// a single sign-correction cycle that writes HI/LO.
//
// Handshake: a request is taken on a rising edge where start=1, busy=0 and
// cancel=0. busy stays high from the accepting edge until the edge that
// writes HI/LO; done pulses for the one cycle after that edge. Because busy
// is already low in the done cycle, a new request may be taken there. cancel
// while busy abandons the operation without a done pulse and leaves HI/LO
// untouched; cancel in IDLE only blocks a simultaneous start.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // FSM state (observable hierarchically as state_q for checkers)
  state_t state_q, state_d;

  // Latched request
  logic [CW-1:0]      cnt_q;
  logic               is_div_q;
  logic               neg_main_q;  // negate product / quotient
  logic               neg_rem_q;   // negate remainder (sign of dividend)
  logic               div_zero_q;
  logic [WIDTH-1:0]   a_raw_q;     // raw dividend, returned in HI on divide-by-zero
  logic [WIDTH-1:0]   opnd_q;      // multiplicand magnitude or divisor magnitude

  // Working accumulator: {upper half, lower half}
  //   multiply: {partial product high, remaining multiplier bits / product low}
  //   divide:   {partial remainder, dividend bits shifting into quotient}
  logic [2*WIDTH-1:0] acc_q;

  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  // Control strobes
  logic accept, iterate, write_res;

  // Operand preparation
  logic             op_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  // Iteration datapath
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [2*WIDTH-1:0] acc_next;

  // Result formatting
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic [WIDTH-1:0]   hi_res, lo_res;

  // Next-state and control strobes
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    iterate   = 1'b0;
    write_res = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          iterate = 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          write_res = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand magnitudes and sign flags for the incoming request
  always_comb begin
    op_signed = ~op[0];
    a_neg     = op_signed & a[WIDTH-1];
    b_neg     = op_signed & b[WIDTH-1];
    mag_a     = a_neg ? (~a + WIDTH'(1)) : a;
    mag_b     = b_neg ? (~b + WIDTH'(1)) : b;
  end

  // One shift-add or restoring shift-subtract step
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    rem_next  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    if (is_div_q) begin
      acc_next = {rem_next, acc_q[WIDTH-2:0], div_ge};
    end else begin
      acc_next = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Sign correction and special-case selection for HI/LO
  always_comb begin
    prod_fix = neg_main_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
    quot_fix = neg_main_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc_q[2*WIDTH-1:WIDTH];
    if (!is_div_q) begin
      hi_res = prod_fix[2*WIDTH-1:WIDTH];
      lo_res = prod_fix[WIDTH-1:0];
    end else if (div_zero_q) begin
      hi_res = a_raw_q;
      lo_res = {WIDTH{1'b1}};
    end else begin
      hi_res = rem_fix;
      lo_res = quot_fix;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch, iteration counter and accumulator
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      a_raw_q    <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
    end else if (accept) begin
      cnt_q      <= '0;
      is_div_q   <= op[1];
      neg_main_q <= a_neg ^ b_neg;
      neg_rem_q  <= a_neg;
      div_zero_q <= (b == '0);
      a_raw_q    <= a;
      opnd_q     <= op[1] ? mag_b : mag_a;
      acc_q      <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
    end else if (iterate) begin
      cnt_q <= cnt_q + CW'(1);
      acc_q <= acc_next;
    end
  end

  // Architectural HI/LO and the done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= write_res;
      if (write_res) begin
        hi_q <= hi_res;
        lo_q <= lo_res;
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
